// File: rtl/trail_stack.sv
// trail_stack: LIFO of DATA_W-bit literals, each tagged with a decision bit, tracking
// the current decision level. Supports single pop, push+pop replace-top, and a
// multi-cycle backtrack-to-level that streams one removed entry per cycle.
// Optional feature macro: TRAIL_STACK_PEAK_EN adds i_peak_clear / o_peak_count
// (high-water mark of occupancy since reset).
module trail_stack #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LEVEL_W = 8,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_push,
  input  logic [DATA_W-1:0]  i_push_data,
  input  logic               i_push_decision,
  input  logic               i_pop,
  input  logic               i_backtrack,
  input  logic [LEVEL_W-1:0] i_bt_level,
`ifdef TRAIL_STACK_PEAK_EN
  input  logic               i_peak_clear,
  output logic [CNT_W-1:0]   o_peak_count,
`endif
  output logic               o_pop_valid,
  output logic [DATA_W-1:0]  o_pop_data,
  output logic               o_pop_decision,
  output logic [DATA_W-1:0]  o_top_data,
  output logic [CNT_W-1:0]   o_count,
  output logic [LEVEL_W-1:0] o_level,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_busy,
  output logic               o_bt_done,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = '1;

  typedef enum logic [0:0] {StIdle, StBacktrack} state_e;

  // Storage entry: {decision, literal}
  logic [DATA_W:0]    r_mem [DEPTH];

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_count, w_count_d;
  logic [LEVEL_W-1:0] r_level, w_level_d;
  logic [LEVEL_W-1:0] r_bt_level, w_bt_level_d;
  logic               r_pop_valid, w_pop_valid_d;
  logic [DATA_W-1:0]  r_pop_data, w_pop_data_d;
  logic               r_pop_dec, w_pop_dec_d;
  logic               r_bt_done, w_bt_done_d;
  logic               r_overflow, w_overflow_d;
  logic               r_underflow, w_underflow_d;

  logic               w_empty;
  logic               w_full;
  logic [IDX_W-1:0]   w_top_idx;
  logic [DATA_W:0]    w_top_entry;
  logic               w_we;
  logic [IDX_W-1:0]   w_widx;
  logic [LEVEL_W-1:0] w_lvl_tmp;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_FULL);
  // Wraps to DEPTH-1 when count==DEPTH and DEPTH is a power of two.
  assign w_top_idx   = r_count[IDX_W-1:0] - IDX_W'(1);
  assign w_top_entry = r_mem[w_top_idx];

  function automatic logic [LEVEL_W-1:0] lvl_inc(input logic [LEVEL_W-1:0] l);
    return (l == LVL_MAX) ? l : l + LEVEL_W'(1);
  endfunction

  function automatic logic [LEVEL_W-1:0] lvl_dec(input logic [LEVEL_W-1:0] l);
    return (l == '0) ? l : l - LEVEL_W'(1);
  endfunction

  // Next-state logic: IDLE priority is backtrack > push/pop; BACKTRACK removes one entry per cycle
  always_comb begin
    w_state_d     = r_state;
    w_count_d     = r_count;
    w_level_d     = r_level;
    w_bt_level_d  = r_bt_level;
    w_pop_valid_d = 1'b0;
    w_pop_data_d  = r_pop_data;
    w_pop_dec_d   = r_pop_dec;
    w_bt_done_d   = 1'b0;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;
    w_we          = 1'b0;
    w_widx        = r_count[IDX_W-1:0];
    w_lvl_tmp     = r_level;

    unique case (r_state)
      StIdle: begin
        if (i_backtrack) begin
          if (i_bt_level >= r_level) begin
            w_bt_done_d = 1'b1;
          end else begin
            w_state_d    = StBacktrack;
            w_bt_level_d = i_bt_level;
          end
        end else if (i_push && i_pop && !w_empty) begin
          // Replace top: emit old entry, overwrite in place
          w_we          = 1'b1;
          w_widx        = w_top_idx;
          w_pop_valid_d = 1'b1;
          w_pop_data_d  = w_top_entry[DATA_W-1:0];
          w_pop_dec_d   = w_top_entry[DATA_W];
          w_lvl_tmp     = w_top_entry[DATA_W] ? lvl_dec(r_level) : r_level;
          w_level_d     = i_push_decision ? lvl_inc(w_lvl_tmp) : w_lvl_tmp;
        end else if (i_push) begin
          if (w_full) begin
            w_overflow_d = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_count_d = r_count + CNT_W'(1);
            w_level_d = i_push_decision ? lvl_inc(r_level) : r_level;
          end
        end else if (i_pop) begin
          if (w_empty) begin
            w_underflow_d = 1'b1;
          end else begin
            w_pop_valid_d = 1'b1;
            w_pop_data_d  = w_top_entry[DATA_W-1:0];
            w_pop_dec_d   = w_top_entry[DATA_W];
            w_count_d     = r_count - CNT_W'(1);
            w_level_d     = w_top_entry[DATA_W] ? lvl_dec(r_level) : r_level;
          end
        end
      end

      StBacktrack: begin
        if (w_empty) begin
          w_bt_done_d = 1'b1;
          w_state_d   = StIdle;
        end else begin
          w_pop_valid_d = 1'b1;
          w_pop_data_d  = w_top_entry[DATA_W-1:0];
          w_pop_dec_d   = w_top_entry[DATA_W];
          w_count_d     = r_count - CNT_W'(1);
          w_level_d     = w_top_entry[DATA_W] ? lvl_dec(r_level) : r_level;
          // Last removal: a decision entry bringing level down to target, or stack drained
          if ((w_top_entry[DATA_W] && (w_level_d == r_bt_level)) || (r_count == CNT_W'(1))) begin
            w_bt_done_d = 1'b1;
            w_state_d   = StIdle;
          end
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // Control and output registers, asynchronously reset
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_count     <= '0;
      r_level     <= '0;
      r_bt_level  <= '0;
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_pop_dec   <= 1'b0;
      r_bt_done   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_count     <= w_count_d;
      r_level     <= w_level_d;
      r_bt_level  <= w_bt_level_d;
      r_pop_valid <= w_pop_valid_d;
      r_pop_data  <= w_pop_data_d;
      r_pop_dec   <= w_pop_dec_d;
      r_bt_done   <= w_bt_done_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // Storage array write port; contents deliberately not reset
  always_ff @(posedge i_clock) begin
    if (w_we) begin
      r_mem[w_widx] <= {i_push_decision, i_push_data};
    end
  end

`ifdef TRAIL_STACK_PEAK_EN
  logic [CNT_W-1:0] r_peak;

  // High-water mark of occupancy; clear snaps it to the current count
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_peak <= '0;
    end else if (i_peak_clear) begin
      r_peak <= r_count;
    end else if (w_count_d > r_peak) begin
      r_peak <= w_count_d;
    end
  end

  assign o_peak_count = r_peak;
`endif

  assign o_pop_valid    = r_pop_valid;
  assign o_pop_data     = r_pop_data;
  assign o_pop_decision = r_pop_dec;
  assign o_top_data     = w_empty ? '0 : w_top_entry[DATA_W-1:0];
  assign o_count        = r_count;
  assign o_level        = r_level;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_busy         = (r_state == StBacktrack);
  assign o_bt_done      = r_bt_done;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
